// File: rtl/vlc_deser_sync.sv
// VLC receive deserializer: sync hunt, word assembly, framing,
// and a 2-entry output buffer with sticky overflow.
module vlc_deser_sync #(
  parameter int              WIDTH       = 8,
  parameter bit              MSB_FIRST   = 1'b1,
  parameter logic [WIDTH-1:0] SYNC_WORD  = 'hA5,
  parameter int              FRAME_WORDS = 16,
  parameter bit              SYNC_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             relock,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             locked,
  output logic             frame_done,
  output logic             overflow
);

  typedef enum logic {HUNT, LOCKED} st_e;

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [15:0] FW = 16'(FRAME_WORDS);
  // Idle state: where reset, relock and end of frame land.
  localparam st_e IDLE_ST = SYNC_EN ? HUNT : LOCKED;

  st_e              state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [15:0]      word_cnt_q;
  logic [WIDTH-1:0] ent0_q;
  logic [WIDTH-1:0] ent1_q;
  logic [1:0]       cnt_q;
  logic             fd_q;
  logic             ovf_q;

  logic [WIDTH-1:0] sh_d;
  logic [15:0]      word_inc;
  logic             take;
  logic             push;
  logic             pop;
  logic             last_word;

  always_comb begin
    if (MSB_FIRST) begin
      sh_d = {sreg_q[WIDTH-2:0], in_bit};
    end else begin
      sh_d = {in_bit, sreg_q[WIDTH-1:1]};
    end
    take      = in_valid & ~relock;
    push      = take & (state_q == LOCKED)
              & (bit_cnt_q == LAST_BIT);
    pop       = out_valid & out_ready;
    word_inc  = word_cnt_q + 16'd1;
    last_word = SYNC_EN && (word_inc == FW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE_ST;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      ent0_q     <= '0;
      ent1_q     <= '0;
      cnt_q      <= 2'd0;
      fd_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      fd_q <= 1'b0;

      case (cnt_q)
        2'd0: begin
          if (push) begin
            ent0_q <= sh_d;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            ent0_q <= sh_d;
          end else if (pop) begin
            cnt_q <= 2'd0;
          end else if (push) begin
            ent1_q <= sh_d;
            cnt_q  <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            ent0_q <= ent1_q;
            if (push) begin
              ent1_q <= sh_d;
            end else begin
              cnt_q <= 2'd1;
            end
          end else if (push) begin
            ovf_q <= 1'b1;
          end
        end
      endcase

      if (relock) begin
        state_q    <= IDLE_ST;
        sreg_q     <= '0;
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
      end else if (take) begin
        case (state_q)
          HUNT: begin
            if (sh_d == SYNC_WORD) begin
              state_q    <= LOCKED;
              sreg_q     <= '0;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
            end else begin
              sreg_q <= sh_d;
            end
          end
          default: begin
            if (!push) begin
              sreg_q    <= sh_d;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end else if (last_word) begin
              fd_q       <= 1'b1;
              state_q    <= IDLE_ST;
              sreg_q     <= '0;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
            end else begin
              sreg_q    <= sh_d;
              bit_cnt_q <= '0;
              // Free-run has no frame, so word_cnt never advances.
              if (SYNC_EN) begin
                word_cnt_q <= word_inc;
              end
            end
          end
        endcase
      end
    end
  end

  assign out_data   = ent0_q;
  assign out_valid  = (cnt_q != 2'd0);
  assign locked     = (state_q == LOCKED);
  assign frame_done = fd_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_vlc_deser_sync.sv
// Bench for vlc_deser_sync: four configurations share one stimulus
// stream; each is checked every cycle against a behavioural model.
module tb_vlc_deser_sync;

  logic clk = 1'b0;
  logic rst;
  logic in_bit;
  logic in_valid;
  logic relock;
  logic out_ready;

  logic [7:0] od [4];
  logic       ov [4];
  logic       lk [4];
  logic       fd [4];
  logic       of [4];

  int nvec = 0;
  int nerr = 0;

  bit  msbk [4];
  bit  senk [4];
  int  fwk  [4];

  bit         mlk  [4];
  int         mnb  [4];
  int         mnw  [4];
  logic [7:0] macc [4];
  logic [7:0] mq   [4][$];
  bit         movf [4];
  bit         mfd  [4];

  always #5 clk = ~clk;

  vlc_deser_sync #(.MSB_FIRST(1), .FRAME_WORDS(2)) u0 (
    .clk(clk), .rst(rst), .in_bit(in_bit),
    .in_valid(in_valid), .relock(relock),
    .out_data(od[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .locked(lk[0]),
    .frame_done(fd[0]), .overflow(of[0]));

  vlc_deser_sync #(.MSB_FIRST(0), .FRAME_WORDS(2)) u1 (
    .clk(clk), .rst(rst), .in_bit(in_bit),
    .in_valid(in_valid), .relock(relock),
    .out_data(od[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .locked(lk[1]),
    .frame_done(fd[1]), .overflow(of[1]));

  vlc_deser_sync u2 (
    .clk(clk), .rst(rst), .in_bit(in_bit),
    .in_valid(in_valid), .relock(relock),
    .out_data(od[2]), .out_valid(ov[2]),
    .out_ready(out_ready), .locked(lk[2]),
    .frame_done(fd[2]), .overflow(of[2]));

  vlc_deser_sync #(.SYNC_EN(0)) u3 (
    .clk(clk), .rst(rst), .in_bit(in_bit),
    .in_valid(in_valid), .relock(relock),
    .out_data(od[3]), .out_valid(ov[3]),
    .out_ready(out_ready), .locked(lk[3]),
    .frame_done(fd[3]), .overflow(of[3]));

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    bit pop;
    bit push;
    logic [7:0] w;
    push = 1'b0;
    w = 8'h00;
    if (rst) begin
      mlk[k] = !senk[k];
      mnb[k] = 0;
      mnw[k] = 0;
      macc[k] = 8'h00;
      mq[k].delete();
      movf[k] = 1'b0;
      mfd[k] = 1'b0;
      return;
    end
    pop = (mq[k].size() > 0) && out_ready;
    mfd[k] = 1'b0;
    if (relock) begin
      macc[k] = 8'h00;
      mnb[k] = 0;
      mnw[k] = 0;
      if (senk[k]) mlk[k] = 1'b0;
    end else if (in_valid) begin
      if (msbk[k])
        macc[k] = 8'((macc[k] * 2 + in_bit) % 256);
      else
        macc[k] = 8'(macc[k] / 2 + (in_bit ? 128 : 0));
      if (!mlk[k]) begin
        if (macc[k] == 8'hA5) begin
          mlk[k] = 1'b1;
          macc[k] = 8'h00;
          mnb[k] = 0;
          mnw[k] = 0;
        end
      end else begin
        mnb[k]++;
        if (mnb[k] == 8) begin
          push = 1'b1;
          w = macc[k];
          mnb[k] = 0;
          if (senk[k]) begin
            mnw[k]++;
            if (mnw[k] == fwk[k]) begin
              mfd[k] = 1'b1;
              mlk[k] = 1'b0;
              macc[k] = 8'h00;
              mnw[k] = 0;
            end
          end
        end
      end
    end
    if (pop) void'(mq[k].pop_front());
    if (push) begin
      if (mq[k].size() < 2) mq[k].push_back(w);
      else movf[k] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lock%0d", k), 32'(lk[k]), 32'(mlk[k]));
      chk($sformatf("valid%0d", k), 32'(ov[k]),
          32'(mq[k].size() > 0));
      if (mq[k].size() > 0)
        chk($sformatf("data%0d", k), 32'(od[k]),
            32'(mq[k][0]));
      chk($sformatf("fdone%0d", k), 32'(fd[k]), 32'(mfd[k]));
      chk($sformatf("ovf%0d", k), 32'(of[k]), 32'(movf[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 4; k++) model_step(k);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    in_bit = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v,
                           input bit msb);
    for (int i = 0; i < 8; i++)
      send_bit(msb ? v[7-i] : v[i]);
  endtask

  task automatic send_bit_r(input logic b);
    repeat ($urandom_range(0, 2)) begin
      out_ready = 1'($urandom);
      tick();
    end
    out_ready = 1'($urandom);
    send_bit(b);
  endtask

  initial begin
    logic [7:0] v;
    int r;
    msbk = '{1, 0, 1, 1};
    senk = '{1, 1, 1, 0};
    fwk  = '{2, 2, 16, 16};
    rst = 1'b1;
    in_bit = 1'b0;
    in_valid = 1'b0;
    relock = 1'b0;
    out_ready = 1'b1;
    do_rst();

    chk("rst_data", 32'(od[0]), 32'h0);
    chk("rst_valid", 32'(ov[0]), 32'h0);
    chk("rst_lock", 32'(lk[0]), 32'h0);
    chk("rst_ovf", 32'(of[0]), 32'h0);
    chk("rst_fd", 32'(fd[0]), 32'h0);
    chk("rst_lock_free", 32'(lk[3]), 32'h1);

    send_byte(8'hA5, 1);
    chk("t1_lock", 32'(lk[0]), 32'h1);
    send_byte(8'h3C, 1);
    chk("t1_w0v", 32'(ov[0]), 32'h1);
    chk("t1_w0", 32'(od[0]), 32'h3C);
    send_byte(8'hC3, 1);
    chk("t1_w1", 32'(od[0]), 32'hC3);
    chk("t1_fd", 32'(fd[0]), 32'h1);
    chk("t1_unlock", 32'(lk[0]), 32'h0);
    tick();
    chk("t1_fd_off", 32'(fd[0]), 32'h0);

    do_rst();
    send_byte(8'hA5, 0);
    chk("t2_lock", 32'(lk[1]), 32'h1);
    send_byte(8'h3C, 0);
    chk("t2_w0", 32'(od[1]), 32'h3C);

    do_rst();
    send_byte(8'hA5, 1);
    out_ready = 1'b0;
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_byte(8'h33, 1);
    chk("t3_hold", 32'(od[2]), 32'h11);
    chk("t3_ovf", 32'(of[2]), 32'h1);
    out_ready = 1'b1;
    tick();
    chk("t3_pop1", 32'(od[2]), 32'h22);
    tick();
    chk("t3_empty", 32'(ov[2]), 32'h0);
    chk("t3_sticky", 32'(of[2]), 32'h1);

    out_ready = 1'b0;
    send_byte(8'h44, 1);
    chk("t6_buf", 32'(ov[2]), 32'h1);
    do_rst();
    chk("t6_valid", 32'(ov[2]), 32'h0);
    chk("t6_ovf", 32'(of[2]), 32'h0);
    chk("t6_lock", 32'(lk[2]), 32'h0);
    chk("t6_free_lock", 32'(lk[3]), 32'h1);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    chk("t6_free_w0", 32'(od[3]), 32'h12);
    chk("t6_free_fd", 32'(fd[3]), 32'h0);
    chk("t6_free_ovf", 32'(of[3]), 32'h0);
    out_ready = 1'b1;
    tick();
    chk("t6_free_w1", 32'(od[3]), 32'h34);

    do_rst();
    send_byte(8'hA5, 1);
    out_ready = 1'b0;
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    v = 8'h33;
    for (int i = 0; i < 7; i++) send_bit(v[7-i]);
    out_ready = 1'b1;
    send_bit(v[0]);
    out_ready = 1'b0;
    chk("t4_head", 32'(od[2]), 32'h22);
    chk("t4_ovf", 32'(of[2]), 32'h0);
    out_ready = 1'b1;
    tick();
    chk("t4_next", 32'(od[2]), 32'h33);

    do_rst();
    send_byte(8'hA5, 1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    relock = 1'b1;
    in_valid = 1'b1;
    in_bit = 1'b1;
    tick();
    relock = 1'b0;
    in_valid = 1'b0;
    chk("t5_unlock", 32'(lk[2]), 32'h0);
    chk("t5_noword", 32'(ov[2]), 32'h0);
    send_byte(8'hA5, 1);
    chk("t5_relock", 32'(lk[2]), 32'h1);
    send_byte(8'h5A, 1);
    chk("t5_word", 32'(od[2]), 32'h5A);

    for (int s = 0; s < 80; s++) begin
      r = $urandom_range(0, 9);
      if (r == 0) do_rst();
      if (r == 1) begin
        relock = 1'b1;
        in_valid = 1'($urandom);
        in_bit = 1'($urandom);
        tick();
        relock = 1'b0;
        in_valid = 1'b0;
      end
      r = $urandom_range(0, 2);
      if (r == 2) begin
        for (int i = 0; i < 16; i++)
          send_bit_r(1'($urandom));
      end else begin
        v = 8'hA5;
        for (int i = 0; i < 8; i++)
          send_bit_r(r == 0 ? v[7-i] : v[i]);
        v = 8'($urandom);
        for (int i = 0; i < 8; i++)
          send_bit_r(v[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
